// File: rtl/bypass_ctrl.sv
`default_nettype none
// bypass_ctrl: accepts one N-lane vector, kicks the VFU, holds the vector until
// vfu_done, then presents it downstream. Optional watchdog: BYPASS_CTRL_TIMEOUT_EN.
module bypass_ctrl #(
  parameter int N       = 4,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WIDTH-1:0] in_vec,
  output logic               vfu_start,
  input  logic               vfu_done,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*WIDTH-1:0] out_vec,
  output logic               busy,
  output logic               err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] bypass_q [N];
  logic             acc;

  // A vector can be taken in OUT only in the same cycle the held one leaves.
  assign in_ready  = (state == S_IDLE) || ((state == S_OUT) && out_ready);
  assign acc       = in_valid && in_ready;
  assign out_valid = (state == S_OUT);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        bypass_q[i] <= '0;
      end else if (acc) begin
        bypass_q[i] <= in_vec[i*WIDTH +: WIDTH];
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    assign out_vec[g*WIDTH +: WIDTH] = bypass_q[g];
  end

`ifdef BYPASS_CTRL_TIMEOUT_EN
  localparam int              CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] wd_cnt;
  logic             err_q;

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      vfu_start <= 1'b0;
`ifdef BYPASS_CTRL_TIMEOUT_EN
      wd_cnt    <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      vfu_start <= acc;
`ifdef BYPASS_CTRL_TIMEOUT_EN
      // Every accept is an entry into WAIT, so it restarts the watchdog.
      if (acc) begin
        wd_cnt <= '0;
      end
`endif
      case (state)
        S_IDLE: begin
          if (acc) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (vfu_done) begin
            state <= S_OUT;
`ifdef BYPASS_CTRL_TIMEOUT_EN
          end else if (wd_cnt == CNT_LAST) begin
            state <= S_IDLE;
            err_q <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
`endif
          end
        end
        S_OUT: begin
          if (out_ready) begin
            state <= in_valid ? S_WAIT : S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bypass_ctrl.sv
`default_nettype none
// tb_bypass_ctrl: directed stimulus, cycle-level reference model, literal spot checks.
module tb_bypass_ctrl;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int VW = N * W;
  localparam int TO = 8;
`ifdef BYPASS_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, vfu_start, vfu_done;
  logic          out_valid, out_ready, busy, err;
  logic [VW-1:0] in_vec, out_vec;

  always #5 clk = ~clk;

  bypass_ctrl #(.N(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .vfu_start(vfu_start), .vfu_done(vfu_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
    .busy(busy), .err(err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 waiting on VFU, 2 presenting downstream.
  int          m_phase = 0;
  int          m_wait  = 0;
  logic [63:0] m_vec   = '0;
  logic        m_start = 1'b0;
  logic        m_err   = 1'b0;
  bit          m_known = 1'b0;

  function automatic bit m_ready();
    return (m_phase == 0) || ((m_phase == 2) && (out_ready === 1'b1));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_known <= 1'b1;
      m_phase <= 0;
      m_wait  <= 0;
      m_vec   <= '0;
      m_start <= 1'b0;
      m_err   <= 1'b0;
    end else if (m_known) begin
      m_start <= in_valid && m_ready();
      if (in_valid && m_ready()) m_vec <= in_vec;
      case (m_phase)
        0: if (in_valid) begin m_phase <= 1; m_wait <= 0; end
        1: begin
          if (vfu_done) m_phase <= 2;
          else if (TO_EN && (m_wait == TO - 1)) begin m_phase <= 0; m_err <= 1'b1; end
          else m_wait <= m_wait + 1;
        end
        default: if (out_ready) begin
          if (in_valid) begin m_phase <= 1; m_wait <= 0; end
          else m_phase <= 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    #3;
    if (m_known) begin
      chk("m_in_ready", in_ready, m_ready());
      chk("m_vfu_start", vfu_start, m_start);
      chk("m_out_valid", out_valid, m_phase == 2);
      chk("m_out_vec", out_vec, m_vec);
      chk("m_busy", busy, m_phase != 0);
      chk("m_err", err, m_err);
    end
  end

  task automatic cyc(input logic r, input logic iv, input logic [63:0] v,
                     input logic d, input logic ordy);
    @(negedge clk);
    rst = r; in_valid = iv; in_vec = v; vfu_done = d; out_ready = ordy;
    #3;
  endtask

  localparam logic [63:0] V1 = 64'h0004_0003_0002_0001;
  localparam logic [63:0] V2 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] V3 = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] V4 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] V5 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] V6 = 64'h5A5A_A5A5_0F0F_F0F0;
  localparam logic [63:0] V7 = 64'h7777_0000_8888_FFFF;
  localparam logic [63:0] V8 = 64'hDEAD_BEEF_CAFE_F00D;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_vec = '0; vfu_done = 1'b0; out_ready = 1'b0;

    // Reset then idle
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_vec", out_vec, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);

    // Single operation, done three cycles after accept
    cyc(0, 1, V1, 0, 1);
    chk("op_accept_ready", in_ready, 1);
    cyc(0, 0, 0, 0, 1);
    chk("op_start_k1", vfu_start, 1);
    chk("op_busy_k1", busy, 1);
    cyc(0, 0, 0, 0, 1);
    chk("op_start_k2", vfu_start, 0);
    cyc(0, 0, 0, 1, 1);
    chk("op_outv_k3", out_valid, 0);
    cyc(0, 0, 0, 0, 1);
    chk("op_outv_k4", out_valid, 1);
    chk("op_vec_k4", out_vec, V1);
    cyc(0, 0, 0, 0, 1);
    chk("op_outv_k5", out_valid, 0);
    chk("op_busy_k5", busy, 0);

    // Backpressure with a new vector waiting
    cyc(0, 1, V2, 0, 0);
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, V3, 0, 0);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_vec", out_vec, V2);
      chk("bp_start", vfu_start, 0);
      chk("bp_outv", out_valid, 1);
    end
    cyc(0, 1, V3, 0, 1);
    chk("bp_release_ready", in_ready, 1);
    cyc(0, 0, 0, 1, 1);
    chk("bp_new_start", vfu_start, 1);
    chk("bp_new_vec", out_vec, V3);
    cyc(0, 0, 0, 0, 1);
    chk("bp_new_out", out_valid, 1);

    // Zero-latency VFU, back-to-back
    cyc(0, 1, V4, 1, 1);
    cyc(0, 0, 0, 1, 1);
    chk("zl_start", vfu_start, 1);
    cyc(0, 1, V5, 1, 1);
    chk("zl_outv", out_valid, 1);
    chk("zl_vec", out_vec, V4);
    chk("zl_b2b_ready", in_ready, 1);
    cyc(0, 0, 0, 1, 1);
    chk("zl_b2b_start", vfu_start, 1);
    cyc(0, 0, 0, 1, 1);
    chk("zl_b2b_vec", out_vec, V5);
    chk("zl_b2b_outv", out_valid, 1);

    // Stray done while idle
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 1);
      chk("stray_busy", busy, 0);
      chk("stray_outv", out_valid, 0);
    end

    // Watchdog: no done at all
    cyc(0, 1, V6, 0, 1);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 0, 1);
      chk("wd_busy_wait", busy, 1);
    end
    cyc(0, 0, 0, 0, 1);
    chk("wd_busy_after", busy, !TO_EN);
    chk("wd_err_after", err, TO_EN);
    if (busy) begin
      cyc(0, 0, 0, 1, 1);
      cyc(0, 0, 0, 0, 1);
      chk("wd_late_out", out_vec, V6);
    end
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("wd_err_cleared", err, 0);

    // Watchdog: done in the 8th WAIT cycle wins
    cyc(0, 1, V7, 0, 1);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1);
    chk("wd_edge_outv", out_valid, 1);
    chk("wd_edge_vec", out_vec, V7);
    chk("wd_edge_err", err, 0);

    // Reset while presenting
    cyc(0, 1, V8, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("rmo_outv_before", out_valid, 1);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("rmo_outv", out_valid, 0);
    chk("rmo_vec", out_vec, 0);
    chk("rmo_in_ready", in_ready, 1);
    chk("rmo_busy", busy, 0);

    cyc(0, 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/bypass_ctrl.md
# bypass_ctrl

Sequencing controller for the VFU bypass path: accepts one N-lane vector per operation over a valid/ready handshake and captures it into an internal bypass register array. It issues a start pulse to the VFU compute pipeline and holds the captured vector until the VFU reports completion. It then presents the held vector downstream, aligned with the VFU result, until the consumer accepts it. It sits between the LN input stage and the VFU result merge.

## Interface
- N, 4, number of lanes
- WIDTH, 16, bits per lane
- TIMEOUT, 64, watchdog limit in WAIT cycles; only used with BYPASS_CTRL_TIMEOUT_EN; must be >= 2

- clk  input  1  single clock, all logic rising-edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream vector valid
- in_ready  output  1  controller can accept a vector this cycle
- in_vec  input  N*WIDTH  upstream vector, lane i at [i*WIDTH +: WIDTH]
- vfu_start  output  1  one-cycle pulse: VFU operation begins
- vfu_done  input  1  VFU result ready; sampled only in WAIT
- out_valid  output  1  held vector available downstream
- out_ready  input  1  downstream accepts
- out_vec  output  N*WIDTH  held bypass vector, same lane packing
- busy  output  1  state != IDLE
- err  output  1  sticky watchdog error; constant 0 without the macro

## Operation
- Storage: internal bypass register array of N lanes x WIDTH. It uses one shared enable. Its reset value is 0. out_vec is driven directly from this register, not gated by out_valid.
- The storage enable equals the accept signal, acc = in_valid && in_ready. Storage never loads on any other cycle.
- FSM states:
  - IDLE → WAIT on acc.
  - WAIT → OUT when vfu_done = 1.
  - WAIT → IDLE on watchdog expiry (macro only).
  - OUT → IDLE when out_ready && !in_valid.
  - OUT → WAIT when out_ready && in_valid (back-to-back accept).
  - OUT holds when !out_ready.
- in_ready = (state == IDLE) || (state == OUT && out_ready). in_ready is combinational from out_ready. There is no combinational path from in_valid to in_ready.
- vfu_start is registered. It is 1 exactly in the first cycle after every acc, and 0 otherwise.
- out_valid = (state == OUT).
- vfu_done is ignored in IDLE and OUT, with no state change and no error.
- vfu_done in the same cycle as vfu_start, i.e. a zero-latency VFU, is honoured: WAIT → OUT.
- in_vec is a don't-care when acc = 0.

## Timing
- Reset values of outputs: state IDLE, in_ready 1, vfu_start 0, out_valid 0, out_vec 0, busy 0, err 0.
- rst mid-operation, in any state, returns everything to the reset values on the next edge. It abandons the held vector. Any pending vfu_start pulse is cancelled.
- Acceptance timing:
  - acc at edge k loads storage and enters WAIT.
  - vfu_start is high during cycle k+1.
- Completion timing:
  - vfu_done high in cycle m (WAIT) enters OUT at edge m.
  - out_valid is high from cycle m+1.
- Minimum accept-to-out_valid latency is 2 cycles, with vfu_done in cycle k+1.
- Back-to-back throughput: one vector per 2 cycles when vfu_done arrives immediately.
- While out_valid && !out_ready, out_vec stays stable and the storage enable is 0.

## Configuration
- Macro: BYPASS_CTRL_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT) clears on every entry to WAIT.
  - It increments each WAIT cycle without vfu_done.
  - If count == TIMEOUT-1 and vfu_done = 0, the FSM goes WAIT → IDLE at that edge and err is set.
  - err stays 1 until rst; the controller keeps operating.
  - vfu_done in the same cycle as expiry wins: go to OUT, no error.
- Undefined: no counter and no watchdog; WAIT persists indefinitely; err tied to 0.

## Test plan
- Reset then idle:
  - Stimulus: rst 2 cycles, then idle.
  - Required: in_ready=1, out_valid=0, out_vec=0, busy=0, err=0.
- Single operation:
  - Stimulus: accept in_vec=0x0004_0003_0002_0001 at edge k, vfu_done in cycle k+3, out_ready=1.
  - Required: vfu_start high only at k+1; out_valid cycle k+4 only, with out_vec=0x0004_0003_0002_0001.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles in OUT, in_valid=1 with a different vector.
  - Required: in_ready=0, out_vec unchanged, no vfu_start; on out_ready=1 the new vector is accepted the same cycle.
- Zero-latency and stray done:
  - Stimulus 1: vfu_done held high continuously.
  - Required 1: WAIT lasts 1 cycle.
  - Stimulus 2: a vfu_done pulse in IDLE.
  - Required 2: no state change.
- Watchdog:
  - Stimulus (macro on, TIMEOUT=8): accept, never assert vfu_done.
  - Required: busy drops and err=1 after 8 WAIT cycles.
  - Repeat with vfu_done in the 8th WAIT cycle: out_valid follows, err=0.
- Reset mid-OUT:
  - Stimulus: rst while out_valid=1.
  - Required: next cycle out_valid=0, out_vec=0, in_ready=1.
